// File: rtl/color_track_pkg.sv
// Shared types and defaults for the colour centroid tracker.
// Holds resolution, accumulator widths and the tracker FSM encoding.
package color_track_pkg;

  localparam int H_RES_D   = 640;
  localparam int V_RES_D   = 480;
  localparam int TOL_D     = 16;
  localparam int MIN_PIX_D = 64;
  localparam int SUM_W     = 28;
  localparam int CNT_W     = 19;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DIV_X,
    DIV_Y,
    DONE
  } track_state_t;

  // Bayer site select: blue is odd/odd, red is even/even
  function automatic logic site_hit(
    input logic sw,
    input logic x0,
    input logic y0
  );
    return sw ? (x0 & y0) : (~x0 & ~y0);
  endfunction

endpackage

// File: rtl/color_centroid_tracker_if.sv
// Pixel stream in, per-frame tracking result out.
// Master drives the stream, slave is the tracker.
interface color_centroid_tracker_if;

  logic [11:0] iDATA;
  logic        iDATA_VAL;
  logic [15:0] iX_Cont;
  logic [15:0] iY_Cont;
  logic        iFVAL;
  logic [9:0]  oX;
  logic [9:0]  oY;
  logic        oFOUND;
  logic        oTRK_VAL;
  logic        oBUSY;

  modport master (
    output iDATA, iDATA_VAL, iX_Cont, iY_Cont, iFVAL,
    input  oX, oY, oFOUND, oTRK_VAL, oBUSY
  );

  modport slave (
    input  iDATA, iDATA_VAL, iX_Cont, iY_Cont, iFVAL,
    output oX, oY, oFOUND, oTRK_VAL, oBUSY
  );

endinterface

// File: rtl/color_centroid_tracker_seq_divider.sv
// Restoring divider, one quotient bit per clock.
// The start cycle already resolves the first bit; done pulses once.
module seq_divider #(
  parameter int DW = 28,
  parameter int VW = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic          done
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] dq;
  logic [VW-1:0] rem;
  logic [VW-1:0] den;
  logic [CW-1:0] left;
  logic          busy;

  logic [DW-1:0] src_q;
  logic [VW-1:0] src_r;
  logic [VW-1:0] src_d;
  logic [VW:0]   t;
  logic [VW:0]   nr;
  logic          ge;
  logic          unused_top;

  assign src_q = start ? dividend : dq;
  assign src_r = start ? '0 : rem;
  assign src_d = start ? divisor : den;
  assign t     = {src_r, src_q[DW-1]};
  assign ge    = t >= {1'b0, src_d};
  assign nr    = ge ? t - {1'b0, src_d} : t;
  // remainder stays below the divisor, so the top bit is always 0
  assign unused_top = nr[VW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq   <= '0;
      rem  <= '0;
      den  <= '0;
      left <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      dq   <= {src_q[DW-2:0], ge};
      rem  <= nr[VW-1:0];
      den  <= divisor;
      left <= CW'(DW - 1);
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      dq   <= {src_q[DW-2:0], ge};
      rem  <= nr[VW-1:0];
      left <= left - CW'(1);
      if (left == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = dq;

endmodule

// File: rtl/color_centroid_tracker.sv
// Per-frame centroid of Bayer pixels close to the calibrated mean.
// One shared divider produces X then Y after the frame ends.
module color_centroid_tracker
  import color_track_pkg::*;
#(
  parameter int H_RES   = H_RES_D,
  parameter int V_RES   = V_RES_D,
  parameter int TOL     = TOL_D,
  parameter int MIN_PIX = MIN_PIX_D
) (
  input  logic        D5M_PXCLK,
  input  logic        iRST_N,
  input  logic        iEN,
  input  logic        iCOLOR_SW,
  input  logic        iMEAN_VAL,
  input  logic [11:0] iMEAN,
  color_centroid_tracker_if.slave pix
);

  track_state_t state;

  logic        fval_q;
  logic        rise;
  logic        fall;
  logic [11:0] shadow;
  logic        shadow_ok;
  logic [11:0] mean_q;
  logic        mean_ok;

  logic [SUM_W-1:0] sum_x;
  logic [SUM_W-1:0] sum_y;
  logic [CNT_W-1:0] cnt;

  logic signed [12:0] diff;
  logic [12:0] mag;
  logic        close;
  logic        in_view;
  logic        hit;
  logic        take;

  logic             kick;
  logic             div_start;
  logic             div_done;
  logic [SUM_W-1:0] div_q;
  logic             unused_q;

  logic [9:0] res_x;
  logic [9:0] res_y;
  logic       res_found;
  logic [9:0] x_r;
  logic [9:0] y_r;
  logic       found_r;
  logic       trk_r;

  assign rise = pix.iFVAL & ~fval_q;
  assign fall = ~pix.iFVAL & fval_q;

  assign diff = $signed({1'b0, pix.iDATA})
              - $signed({1'b0, mean_q});
  assign mag   = diff[12] ? 13'(-diff) : 13'(diff);
  assign close = mag <= 13'(TOL);

  assign in_view = (pix.iX_Cont < 16'(H_RES))
                 & (pix.iY_Cont < 16'(V_RES));

  assign hit = (state == ACCUM) & iEN & pix.iFVAL
             & pix.iDATA_VAL & mean_ok & close & in_view
             & site_hit(iCOLOR_SW, pix.iX_Cont[0], pix.iY_Cont[0]);

  // a frame is only taken when not dividing and a mean is available
  assign take = rise & iEN & shadow_ok
              & ((state == IDLE) | (state == DONE));

  always_ff @(posedge D5M_PXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fval_q    <= 1'b0;
      shadow    <= '0;
      shadow_ok <= 1'b0;
      mean_q    <= '0;
      mean_ok   <= 1'b0;
    end else begin
      fval_q <= pix.iFVAL;
      if (iMEAN_VAL) begin
        shadow    <= iMEAN;
        shadow_ok <= 1'b1;
      end
      if (rise) begin
        mean_q  <= shadow;
        mean_ok <= shadow_ok;
      end
    end
  end

  always_ff @(posedge D5M_PXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (take) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (hit) begin
      sum_x <= sum_x + SUM_W'(pix.iX_Cont);
      sum_y <= sum_y + SUM_W'(pix.iY_Cont);
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign div_start = kick | ((state == DIV_X) & div_done);

  seq_divider #(
    .DW(SUM_W),
    .VW(CNT_W)
  ) u_div (
    .clk      (D5M_PXCLK),
    .rst_n    (iRST_N),
    .start    (div_start),
    .dividend (kick ? sum_x : sum_y),
    .divisor  (cnt),
    .quotient (div_q),
    .done     (div_done)
  );

  assign unused_q = ^div_q[SUM_W-1:10];

  always_ff @(posedge D5M_PXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      kick      <= 1'b0;
      res_x     <= '0;
      res_y     <= '0;
      res_found <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      found_r   <= 1'b0;
      trk_r     <= 1'b0;
    end else begin
      kick  <= 1'b0;
      trk_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) state <= ACCUM;
        end
        ACCUM: begin
          if (fall) begin
            if (!iEN) begin
              state <= IDLE;
            end else if (cnt < CNT_W'(MIN_PIX)) begin
              res_found <= 1'b0;
              state     <= DONE;
            end else begin
              kick  <= 1'b1;
              state <= DIV_X;
            end
          end
        end
        DIV_X: begin
          if (div_done) begin
            res_x <= div_q[9:0];
            state <= DIV_Y;
          end
        end
        DIV_Y: begin
          if (div_done) begin
            res_y     <= div_q[9:0];
            res_found <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          trk_r   <= 1'b1;
          found_r <= res_found;
          if (res_found) begin
            x_r <= res_x;
            y_r <= res_y;
          end
          state <= take ? ACCUM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pix.oX       = x_r;
  assign pix.oY       = y_r;
  assign pix.oFOUND   = found_r;
  assign pix.oTRK_VAL = trk_r;
  assign pix.oBUSY    = (state == DIV_X) | (state == DIV_Y);

endmodule

// File: tb/tb_color_centroid_tracker.sv
// Scoreboard bench for color_centroid_tracker.
// A frame-level model predicts each published result and its timing.
module tb_color_centroid_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en;
  logic        color_sw;
  logic        mean_val;
  logic [11:0] mean;

  color_centroid_tracker_if pif();

  color_centroid_tracker dut (
    .D5M_PXCLK (clk),
    .iRST_N    (rst_n),
    .iEN       (en),
    .iCOLOR_SW (color_sw),
    .iMEAN_VAL (mean_val),
    .iMEAN     (mean),
    .pix       (pif.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit found;
    int x;
    int y;
    int at;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  int    m_shadow = 0;
  bit    m_shadow_ok = 0;
  int    m_mean = 0;
  bit    m_mean_ok = 0;
  bit    active = 0;
  longint sx, sy;
  int    cnt = 0;
  int    last_x = 0;
  int    last_y = 0;
  int    busy_end = -1;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && pif.oTRK_VAL) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_trk: got pulse at %0d, want none",
                 cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("found", 32'(pif.oFOUND), 32'(e.found));
        check("x", 32'(pif.oX), e.x);
        check("y", 32'(pif.oY), e.y);
        check("latency", cyc, e.at);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mean(int v);
    mean     = 12'(v);
    mean_val = 1'b1;
    m_shadow = v;
    m_shadow_ok = 1;
    @(negedge clk);
    mean_val = 1'b0;
  endtask

  task automatic frame_start();
    int rc;
    pif.iFVAL = 1'b1;
    rc = cyc + 1;
    m_mean    = m_shadow;
    m_mean_ok = m_shadow_ok;
    active = en && m_shadow_ok && (rc > busy_end);
    if (active) begin
      sx = 0;
      sy = 0;
      cnt = 0;
    end
    idle(3);
  endtask

  task automatic pix(int x, int y, int d);
    int df;
    bit site;
    pif.iX_Cont   = 16'(x);
    pif.iY_Cont   = 16'(y);
    pif.iDATA     = 12'(d);
    pif.iDATA_VAL = 1'b1;
    df = d - m_mean;
    if (df < 0) df = -df;
    site = color_sw ? (x % 2 == 1 && y % 2 == 1)
                    : (x % 2 == 0 && y % 2 == 0);
    if (active && en && m_mean_ok && site && x < 640
        && y < 480 && df <= 16) begin
      sx += x;
      sy += y;
      cnt++;
    end
    @(negedge clk);
    pif.iDATA_VAL = 1'b0;
  endtask

  task automatic frame_end();
    int fc;
    exp_t e;
    pif.iFVAL = 1'b0;
    fc = cyc + 1;
    if (active && en) begin
      if (cnt < 64) begin
        e = '{0, last_x, last_y, fc + 1};
        busy_end = fc;
      end else begin
        last_x = int'((sx / cnt) % 1024);
        last_y = int'((sy / cnt) % 1024);
        e = '{1, last_x, last_y, fc + 58};
        busy_end = fc + 57;
      end
      q.push_back(e);
    end
    active = 0;
    idle(2);
  endtask

  task automatic box(int x0, int y0, int d);
    for (int y = y0; y < y0 + 32; y++)
      for (int x = x0; x < x0 + 32; x++)
        pix(x, y, d);
  endtask

  task automatic bg(int n, int d);
    int x, y;
    repeat (n) begin
      x = $urandom_range(0, 639);
      y = $urandom_range(0, 479);
      if ($urandom_range(0, 1) == 1) begin
        x = x | 1;
        y = y | 1;
      end
      pix(x, y, d);
    end
  endtask

  task automatic rand_frame();
    int m, n, x, y, d, s;
    color_sw = 1'($urandom_range(0, 1));
    m = $urandom_range(100, 3900);
    set_mean(m);
    idle(2);
    frame_start();
    n = $urandom_range(20, 400);
    s = color_sw ? 1 : 0;
    repeat (n) begin
      x = $urandom_range(0, 700);
      y = $urandom_range(0, 520);
      if ($urandom_range(0, 9) < 7) begin
        x = (x & ~1) | s;
        y = (y & ~1) | s;
      end
      d = m + $urandom_range(0, 40) - 20;
      if ($urandom_range(0, 9) == 0) d = $urandom_range(0, 4095);
      pix(x, y, d);
    end
    frame_end();
    idle(70);
  endtask

  initial begin
    en = 1'b1;
    color_sw = 1'b1;
    mean_val = 1'b0;
    mean = '0;
    pif.iFVAL = 1'b0;
    pif.iDATA_VAL = 1'b0;
    pif.iDATA = '0;
    pif.iX_Cont = '0;
    pif.iY_Cont = '0;

    idle(3);
    check("rst_x", 32'(pif.oX), 0);
    check("rst_y", 32'(pif.oY), 0);
    check("rst_found", 32'(pif.oFOUND), 0);
    check("rst_trk", 32'(pif.oTRK_VAL), 0);
    check("rst_busy", 32'(pif.oBUSY), 0);
    rst_n = 1'b1;
    idle(3);

    // no mean ever loaded: frame must be ignored
    frame_start();
    bg(200, 82);
    box(100, 200, 82);
    frame_end();
    idle(70);

    set_mean(82);
    idle(2);
    frame_start();
    box(100, 200, 90);
    bg(200, 197);
    frame_end();
    idle(70);

    frame_start();
    repeat (10) pix(301, 301, 90);
    frame_end();
    idle(70);

    // mean change mid-frame only applies to the next frame
    frame_start();
    box(100, 200, 90);
    set_mean(197);
    bg(300, 197);
    frame_end();
    idle(70);
    frame_start();
    box(100, 200, 90);
    bg(300, 197);
    frame_end();
    idle(70);

    set_mean(82);
    idle(2);
    frame_start();
    for (int y = 11; y < 43; y += 2)
      for (int x = 11; x < 43; x += 2) pix(x, y, 98);
    for (int y = 401; y < 433; y += 2)
      for (int x = 501; x < 533; x += 2) pix(x, y, 99);
    for (int y = 100; y < 132; y += 2)
      for (int x = 300; x < 332; x += 2) pix(x, y, 82);
    for (int i = 0; i < 50; i++) pix(640, 2 * i + 1, 82);
    for (int i = 0; i < 50; i++) pix(2 * i + 601, 480, 82);
    frame_end();
    idle(70);

    // a frame starting during the divide is skipped
    frame_start();
    box(300, 300, 90);
    frame_end();
    idle(8);
    frame_start();
    bg(30, 82);
    box(10, 10, 90);
    frame_end();
    idle(80);
    frame_start();
    box(200, 100, 90);
    frame_end();
    idle(70);

    frame_start();
    box(50, 50, 90);
    en = 1'b0;
    bg(20, 82);
    frame_end();
    idle(70);
    en = 1'b1;

    repeat (6) rand_frame();

    color_sw = 1'b1;
    set_mean(82);
    idle(2);
    frame_start();
    box(100, 200, 90);
    frame_end();
    idle(20);
    check("busy_mid_div", 32'(pif.oBUSY), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst2_x", 32'(pif.oX), 0);
    check("rst2_y", 32'(pif.oY), 0);
    check("rst2_found", 32'(pif.oFOUND), 0);
    check("rst2_trk", 32'(pif.oTRK_VAL), 0);
    check("rst2_busy", 32'(pif.oBUSY), 0);
    q.delete();
    m_shadow_ok = 0;
    m_mean_ok = 0;
    last_x = 0;
    last_y = 0;
    busy_end = -1;
    active = 0;
    pif.iFVAL = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    repeat (10) pix(301, 301, 90);
    frame_end();
    idle(80);

    set_mean(82);
    idle(2);
    frame_start();
    box(120, 140, 90);
    frame_end();
    idle(100);

    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
